emg_frame_packer: RTL and testbench
===================================

# emg_frame_packer

Downstream consumer of the EMG acquisition sequencer. It captures each ADC conversion result together with the channel index that was active at conversion start, and checks that channels arrive in order 0..NUM_CH-1. It packs results into headed frames in a 16-bit word stream and buffers them in an on-chip FIFO, which the serializer/host link drains through a valid/ready handshake.

## Interface
- NUM_CH, 16, channels per frame (2..16)
- FIFO_DEPTH, 32, FIFO words; power of 2, ≥ NUM_CH+1
- ADC_BITS, 10, ADC result width (≤10)
- clk_EMG  in  1  block clock (same domain as ADC_CLK_EMG logic)
- RESET  in  1  reset; one clock; reset is synchronous and active-high
- ENABLE  in  1  capture enable
- START_EMG  in  1  one-cycle pulse, conversion start
- CH_SEL_EMG  in  4  channel index, valid in the START_EMG cycle
- ADC_DONE  in  1  one-cycle pulse, result valid
- ADC_DATA  in  ADC_BITS  conversion result, valid with ADC_DONE
- CLR_ERR  in  1  one-cycle pulse, clears sticky flags
- OUT_VALID  out  1  FIFO head word valid
- OUT_READY  in  1  consumer accepts head word
- OUT_DATA  out  16  FIFO head word
- FILL_LEVEL  out  $clog2(FIFO_DEPTH)+1  words stored
- SEQ_ERR  out  1  sticky, channel out of order
- OVF  out  1  sticky, word dropped on full FIFO

## Operation
- Word formats:
  - header = {2'b10, 6'b0, frame_cnt[7:0]}
  - sample = {2'b01, ch[3:0], ADC_DATA zero-extended to 10 bits}
- START_EMG latches CH_SEL_EMG into cur_ch.
- FSM states: IDLE, WAIT_CH0, COLLECT.
  - IDLE: ENABLE=0. START/DONE ignored. Goes to WAIT_CH0 when ENABLE=1.
  - WAIT_CH0: START with ch==0 pushes a header, sets exp_ch=1, and goes to COLLECT. All other STARTs are ignored. DONE pushes nothing.
  - COLLECT: each DONE pushes a sample tagged with cur_ch.
    - A START with ch==exp_ch increments exp_ch.
    - A START with ch≠exp_ch sets SEQ_ERR. If ch==0 it starts a new frame (header pushed); otherwise it goes to WAIT_CH0.
    - After the DONE of channel NUM_CH-1 the FSM returns to WAIT_CH0.
- frame_cnt increments on every header push and wraps 255→0.
- Push rules:
  - A push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the word is dropped, OVF is set, and the FSM goes to WAIT_CH0; the rest of the frame is discarded.
  - A truncated frame stays in the FIFO. The consumer resyncs on the next header.
- Write-port conflict: START and DONE in the same cycle are out of spec but defined. The sample is written first; the header is held in a one-entry pending register and written the next cycle. DONE always has write priority.
- ENABLE falling: the FSM enters IDLE immediately and any pending header is discarded. The FIFO keeps draining. Flags are kept.
- CLR_ERR clears SEQ_ERR and OVF. If a set event occurs in the same cycle, set wins.
- RESET: FSM→IDLE, FIFO emptied, frame_cnt=0, exp_ch=0, pending cleared.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=16'h0000 (empty-FIFO value is forced to 0), FILL_LEVEL=0, SEQ_ERR=0, OVF=0.
- FIFO is first-word-fall-through.
  - A word pushed at edge t gives OUT_VALID=1 in cycle t+1 when the FIFO was empty.
  - Push→visible latency is 1 clock.
- A pop occurs at the edge where OUT_VALID&OUT_READY. The next word appears in the following cycle with no bubble.
- OUT_DATA is stable while OUT_VALID=1 and OUT_READY=0.
- FILL_LEVEL is updated at the same edge as push/pop. A simultaneous push and pop leaves it unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty come from the count register.
- SEQ_ERR and OVF are set at the edge of the offending event and are visible in the next cycle.

## Structure
- Package emg_pkg holds:
  - TAG_HDR=2'b10, TAG_SMP=2'b01
  - WORD_W=16, CH_W=4
  - FSM state enum
  - header/sample pack functions
- Sub-module emg_sync_fifo (parameters WIDTH, DEPTH): single-clock FWFT FIFO with push/pop/count and synchronous active-high reset.
- Top level contains the FSM, cur_ch, exp_ch, frame_cnt, the pending header, and the flags.

## Test plan
1. Nominal run, NUM_CH=16, OUT_READY=1: a full 0..15 sweep produces 16'h8000, then 16'h4000|data for ch0 through 16'h7C00|data for ch15. A second sweep produces header 16'h8001.
2. Sequence error: START order 0,1,3 gives SEQ_ERR=1 the cycle after the ch3 START. Words for ch3 are dropped until the next ch0, and the next header carries frame_cnt+1.
3. Overflow: OUT_READY=0 for 3 sweeps with FIFO_DEPTH=32. FILL_LEVEL saturates at 32 and OVF=1. The first 32 words are intact. After OUT_READY=1, the next header appears only after a ch0 START.
4. Full plus simultaneous pop: at FILL_LEVEL=32 with OUT_READY=1 and DONE, the push is accepted, FILL_LEVEL stays 32, and OVF stays 0.
5. Same-cycle START(ch0)+DONE in WAIT_CH0→COLLECT transition: the sample word precedes the header by 1 cycle and no words are lost.
6. RESET mid-frame (after ch7): the next cycle shows OUT_VALID=0 and FILL_LEVEL=0, and the first header after re-enable is 16'h8000.

Source files
------------

// File: rtl/emg_pkg.sv
// Shared types, constants and word-pack helpers for the EMG frame packer.
package emg_pkg;

  localparam int WORD_W = 16;
  localparam int CH_W   = 4;
  localparam int DATA_W = 10;

  localparam logic [1:0] TAG_HDR = 2'b10;
  localparam logic [1:0] TAG_SMP = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CH0 = 2'd1,
    ST_COLLECT  = 2'd2
  } state_t;

  // Header word: tag, six zero bits, frame counter.
  function automatic logic [WORD_W-1:0] pack_header(input logic [7:0] cnt);
    return {TAG_HDR, 6'b0, cnt};
  endfunction

  // Sample word: tag, channel index, 10-bit result.
  function automatic logic [WORD_W-1:0] pack_sample(input logic [CH_W-1:0] ch,
                                                    input logic [DATA_W-1:0] d);
    return {TAG_SMP, ch, d};
  endfunction

endpackage

// File: rtl/emg_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Full/empty come from the count
// register so pointers can wrap naturally. A push into a full FIFO is
// accepted when a pop happens at the same edge.
module emg_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_req_i,
  output logic                     push_ok_o,
  output logic                     rd_valid_o,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, pop_fire;

  // Push/pop qualification, pointer and count update.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    pop_fire  = pop_req_i & ~empty;
    push_ok_o = push_i & (~full | pop_fire);
    wr_ptr_d  = push_ok_o ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_fire  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push_ok_o) - CW'(pop_fire);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; no reset needed since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Head word, forced to zero while empty.
  always_comb begin
    rd_valid_o = ~empty;
    rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    count_o    = count_q;
  end

endmodule

// File: rtl/emg_frame_packer.sv
// Captures ADC results with their channel index, checks channel order and
// packs headed frames into a FWFT word FIFO drained by valid/ready.
// Handshake: a word transfers at the rising edge where OUT_VALID and
// OUT_READY are both high; OUT_DATA holds while OUT_VALID && !OUT_READY.
module emg_frame_packer
  import emg_pkg::*;
#(
  parameter int NUM_CH     = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int ADC_BITS   = 10
) (
  input  logic                          clk_EMG,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic                          START_EMG,
  input  logic [3:0]                    CH_SEL_EMG,
  input  logic                          ADC_DONE,
  input  logic [ADC_BITS-1:0]           ADC_DATA,
  input  logic                          CLR_ERR,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [15:0]                   OUT_DATA,
  output logic [$clog2(FIFO_DEPTH):0]   FILL_LEVEL,
  output logic                          SEQ_ERR,
  output logic                          OVF,
  output logic [1:0]                    dbg_state
);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [CH_W:0]       exp_ch_q, exp_ch_d;   // one spare bit so it never aliases ch 0
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                pend_q, pend_d;
  logic                seq_err_q, seq_err_d;
  logic                ovf_q, ovf_d;

  logic                start_ev, done_ev, ch_match, ch_zero;
  logic                smp_ev, new_hdr, seq_set, abort_seq, exp_inc;
  logic                hdr_src, push, push_is_hdr, push_ok, drop;
  logic [WORD_W-1:0]   push_word;
  logic [DATA_W-1:0]   adc_ext;

  // Decode START/DONE into frame events for the current state.
  always_comb begin
    start_ev  = ENABLE & START_EMG;
    done_ev   = ENABLE & ADC_DONE;
    ch_match  = ({1'b0, CH_SEL_EMG} == exp_ch_q);
    ch_zero   = (CH_SEL_EMG == '0);
    smp_ev    = 1'b0;
    new_hdr   = 1'b0;
    seq_set   = 1'b0;
    abort_seq = 1'b0;
    exp_inc   = 1'b0;
    case (state_q)
      ST_WAIT_CH0: begin
        // A DONE colliding with the ch0 START belongs to the new frame.
        if (start_ev && ch_zero) begin
          new_hdr = 1'b1;
          smp_ev  = done_ev;
        end
      end
      ST_COLLECT: begin
        smp_ev = done_ev;
        if (start_ev) begin
          if (ch_match) begin
            exp_inc = 1'b1;
          end else begin
            seq_set = 1'b1;
            if (ch_zero) new_hdr   = 1'b1;
            else         abort_seq = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Write port: a sample always wins; a colliding header waits one cycle.
  always_comb begin
    adc_ext                 = '0;
    adc_ext[ADC_BITS-1:0]   = ADC_DATA;
    hdr_src     = ENABLE & (new_hdr | pend_q);
    push        = smp_ev | hdr_src;
    push_is_hdr = hdr_src & ~smp_ev;
    push_word   = smp_ev ? pack_sample(cur_ch_q, adc_ext) : pack_header(frame_cnt_q);
    drop        = push & ~push_ok;
  end

  // Next-state logic; a dropped word abandons the rest of the frame.
  always_comb begin
    state_d = state_q;
    if (!ENABLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_WAIT_CH0;
        ST_WAIT_CH0: if (new_hdr) state_d = ST_COLLECT;
        ST_COLLECT: begin
          if (abort_seq) state_d = ST_WAIT_CH0;
          else if (smp_ev && !new_hdr && cur_ch_q == CH_W'(NUM_CH - 1))
            state_d = ST_WAIT_CH0;
        end
        default:     state_d = ST_IDLE;
      endcase
      if (drop) state_d = ST_WAIT_CH0;
    end
  end

  // Channel tracking, frame counter, pending header and sticky flags.
  always_comb begin
    cur_ch_d    = START_EMG ? CH_SEL_EMG : cur_ch_q;
    exp_ch_d    = exp_ch_q;
    if (new_hdr)      exp_ch_d = (CH_W+1)'(1);
    else if (exp_inc) exp_ch_d = exp_ch_q + (CH_W+1)'(1);
    frame_cnt_d = (push_ok && push_is_hdr) ? frame_cnt_q + 8'd1 : frame_cnt_q;
    pend_d      = smp_ev & hdr_src & ~drop;
    seq_err_d   = seq_set | (seq_err_q & ~CLR_ERR);
    ovf_d       = drop    | (ovf_q     & ~CLR_ERR);
  end

  // State and datapath registers.
  always_ff @(posedge clk_EMG) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cur_ch_q    <= '0;
      exp_ch_q    <= '0;
      frame_cnt_q <= '0;
      pend_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      exp_ch_q    <= exp_ch_d;
      frame_cnt_q <= frame_cnt_d;
      pend_q      <= pend_d;
      seq_err_q   <= seq_err_d;
      ovf_q       <= ovf_d;
    end
  end

  emg_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk_EMG),
    .rst         (RESET),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_req_i   (OUT_READY),
    .push_ok_o   (push_ok),
    .rd_valid_o  (OUT_VALID),
    .rd_data_o   (OUT_DATA),
    .count_o     (FILL_LEVEL)
  );

  // Flag and debug outputs.
  always_comb begin
    SEQ_ERR   = seq_err_q;
    OVF       = ovf_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_emg_frame_packer.sv
// Bench for emg_frame_packer: a per-cycle vector table for short corner
// sequences, plus directed frame sweeps checked by a word scoreboard.
module tb_emg_frame_packer;

  logic        clk_EMG = 1'b0;
  logic        RESET, ENABLE, START_EMG, ADC_DONE, CLR_ERR, OUT_READY;
  logic [3:0]  CH_SEL_EMG;
  logic [9:0]  ADC_DATA;
  logic        OUT_VALID, SEQ_ERR, OVF;
  logic [15:0] OUT_DATA;
  logic [5:0]  FILL_LEVEL;
  logic [1:0]  dbg_state;

  int n_tot  = 0;
  int n_pass = 0;
  bit sb_on  = 1'b0;
  logic [15:0] exp_q[$];

  emg_frame_packer #(.NUM_CH(16), .FIFO_DEPTH(32), .ADC_BITS(10)) dut (
    .clk_EMG    (clk_EMG),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .START_EMG  (START_EMG),
    .CH_SEL_EMG (CH_SEL_EMG),
    .ADC_DONE   (ADC_DONE),
    .ADC_DATA   (ADC_DATA),
    .CLR_ERR    (CLR_ERR),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .FILL_LEVEL (FILL_LEVEL),
    .SEQ_ERR    (SEQ_ERR),
    .OVF        (OVF),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk_EMG = ~clk_EMG;

  typedef struct packed {
    logic       en, st;
    logic [3:0] ch;
    logic       dn;
    logic [9:0] d;
    logic       rdy, clr;
    logic       vld;
    logic [15:0] dat;
    logic [5:0] fill;
    logic       seq, ovf;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic en, st, input logic [3:0] ch, input logic dn,
                              input logic [9:0] d, input logic rdy, clr, vld,
                              input logic [15:0] dat, input logic [5:0] fill,
                              input logic seq, ovf);
    vec_t v;
    v = '{en:en, st:st, ch:ch, dn:dn, d:d, rdy:rdy, clr:clr, vld:vld,
          dat:dat, fill:fill, seq:seq, ovf:ovf};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic cyc();
    @(posedge clk_EMG);
    #1;
  endtask

  function automatic logic [9:0] dat(input int ch, input int k);
    return 10'((ch * 41 + k * 97 + 5) % 1024);
  endfunction

  // One START for a channel followed next cycle by its DONE.
  task automatic send(input int ch, input logic [9:0] d, input bit exp_hdr,
                      input logic [15:0] hdr, input bit exp_smp);
    START_EMG  = 1'b1;
    CH_SEL_EMG = 4'(ch);
    if (exp_hdr) exp_q.push_back(hdr);
    cyc();
    START_EMG = 1'b0;
    ADC_DONE  = 1'b1;
    ADC_DATA  = d;
    if (exp_smp) exp_q.push_back({2'b01, 4'(ch), d});
    cyc();
    ADC_DONE = 1'b0;
  endtask

  task automatic sweep(input logic [15:0] hdr);
    for (int ch = 0; ch < 16; ch++) send(ch, dat(ch, int'(hdr[7:0])), ch == 0, hdr, 1'b1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    exp_q.delete();
    cyc();
  endtask

  task automatic wait_drain(input string name);
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !OUT_VALID) begin
        done_ok = 1'b1;
        break;
      end
      cyc();
    end
    chk(name, {31'b0, done_ok}, 32'd1);
  endtask

  // Scoreboard: a word leaves at the next edge when valid && ready.
  always @(negedge clk_EMG) begin
    if (sb_on && !RESET && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL sb_extra: got word %h expected none", OUT_DATA);
      end else begin
        chk("sb_word", {16'h0, OUT_DATA}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    RESET = 1'b1; ENABLE = 1'b0; START_EMG = 1'b0; ADC_DONE = 1'b0;
    CLR_ERR = 1'b0; OUT_READY = 1'b0; CH_SEL_EMG = 4'h0; ADC_DATA = 10'h0;
    cyc(); cyc();
    RESET = 1'b0;
    cyc();

    // Reset state
    chk("rst_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_data",  {16'b0, OUT_DATA}, 32'd0);
    chk("rst_fill",  {26'b0, FILL_LEVEL}, 32'd0);
    chk("rst_seq",   {31'b0, SEQ_ERR}, 32'd0);
    chk("rst_ovf",   {31'b0, OVF}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);

    //            en st ch dn data   rdy clr vld dat       fill seq ovf
    tbl[0]  = mk(1, 0, 0, 0, 10'h000, 0, 0, 0, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 10'h155, 1, 0, 1, 16'h4155, 1, 0, 0); // START ch0 + DONE
    tbl[2]  = mk(1, 0, 0, 0, 10'h000, 1, 0, 1, 16'h8000, 1, 0, 0); // pending header
    tbl[3]  = mk(1, 0, 0, 1, 10'h3FF, 1, 0, 1, 16'h43FF, 1, 0, 0);
    tbl[4]  = mk(1, 1, 1, 0, 10'h000, 1, 0, 0, 16'h0000, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 10'h001, 0, 0, 1, 16'h4401, 1, 0, 0);
    tbl[6]  = mk(1, 1, 3, 0, 10'h000, 0, 0, 1, 16'h4401, 1, 1, 0); // out of order
    tbl[7]  = mk(1, 0, 0, 1, 10'h222, 0, 0, 1, 16'h4401, 1, 1, 0); // DONE ignored
    tbl[8]  = mk(1, 0, 0, 0, 10'h000, 1, 1, 0, 16'h0000, 0, 0, 0); // clear + pop
    tbl[9]  = mk(1, 1, 0, 0, 10'h000, 0, 0, 1, 16'h8001, 1, 0, 0);
    tbl[10] = mk(1, 1, 2, 0, 10'h000, 0, 1, 1, 16'h8001, 1, 1, 0); // set beats clear
    tbl[11] = mk(0, 0, 0, 0, 10'h000, 1, 0, 0, 16'h0000, 0, 1, 0); // disable, drain
    tbl[12] = mk(0, 1, 0, 0, 10'h000, 0, 0, 0, 16'h0000, 0, 1, 0); // START ignored
    tbl[13] = mk(1, 0, 0, 0, 10'h000, 0, 0, 0, 16'h0000, 0, 1, 0);
    tbl[14] = mk(1, 1, 0, 0, 10'h000, 0, 0, 1, 16'h8002, 1, 1, 0);

    for (int i = 0; i < 15; i++) begin
      ENABLE = tbl[i].en; START_EMG = tbl[i].st; CH_SEL_EMG = tbl[i].ch;
      ADC_DONE = tbl[i].dn; ADC_DATA = tbl[i].d; OUT_READY = tbl[i].rdy;
      CLR_ERR = tbl[i].clr;
      cyc();
      chk($sformatf("vec%0d", i),
          {6'b0, OUT_VALID, OUT_DATA, FILL_LEVEL, SEQ_ERR, OVF},
          {6'b0, tbl[i].vld, tbl[i].dat, tbl[i].fill, tbl[i].seq, tbl[i].ovf});
    end
    START_EMG = 1'b0; ADC_DONE = 1'b0; CLR_ERR = 1'b0;

    sb_on = 1'b1;

    // Nominal: two full sweeps
    ENABLE = 1'b1; OUT_READY = 1'b1;
    do_reset();
    sweep(16'h8000);
    sweep(16'h8001);
    wait_drain("t1_drain");

    // Sequence error: 0,1,3
    do_reset();
    send(0, dat(0, 9), 1'b1, 16'h8000, 1'b1);
    send(1, dat(1, 9), 1'b0, 16'h0000, 1'b1);
    chk("t2_seq_before", {31'b0, SEQ_ERR}, 32'd0);
    START_EMG = 1'b1; CH_SEL_EMG = 4'd3;
    cyc();
    START_EMG = 1'b0;
    chk("t2_seq_set", {31'b0, SEQ_ERR}, 32'd1);
    ADC_DONE = 1'b1; ADC_DATA = 10'h2AA;
    cyc();
    ADC_DONE = 1'b0;
    sweep(16'h8001);
    wait_drain("t2_drain");
    chk("t2_seq_sticky", {31'b0, SEQ_ERR}, 32'd1);
    CLR_ERR = 1'b1; cyc(); CLR_ERR = 1'b0;
    chk("t2_seq_clr", {31'b0, SEQ_ERR}, 32'd0);

    // Overflow: three sweeps with no consumer
    OUT_READY = 1'b0;
    do_reset();
    sweep(16'h8000);
    sweep(16'h8001);
    sweep(16'h8002);
    while (exp_q.size() > 32) void'(exp_q.pop_back());
    chk("t3_fill_full", {26'b0, FILL_LEVEL}, 32'd32);
    chk("t3_ovf", {31'b0, OVF}, 32'd1);
    OUT_READY = 1'b1;
    wait_drain("t3_drain");
    chk("t3_fill_empty", {26'b0, FILL_LEVEL}, 32'd0);
    chk("t3_ovf_sticky", {31'b0, OVF}, 32'd1);
    sweep(16'h8002);
    wait_drain("t3_resync");
    CLR_ERR = 1'b1; cyc(); CLR_ERR = 1'b0;
    chk("t3_ovf_clr", {31'b0, OVF}, 32'd0);

    // Full FIFO plus simultaneous pop
    OUT_READY = 1'b0;
    do_reset();
    sweep(16'h8000);
    for (int ch = 0; ch < 14; ch++) send(ch, dat(ch, 1), ch == 0, 16'h8001, 1'b1);
    chk("t4_fill_full", {26'b0, FILL_LEVEL}, 32'd32);
    START_EMG = 1'b1; CH_SEL_EMG = 4'd14;
    cyc();
    START_EMG = 1'b0;
    ADC_DONE = 1'b1; ADC_DATA = dat(14, 1); OUT_READY = 1'b1;
    exp_q.push_back({2'b01, 4'd14, dat(14, 1)});
    cyc();
    ADC_DONE = 1'b0;
    chk("t4_fill_hold", {26'b0, FILL_LEVEL}, 32'd32);
    chk("t4_no_ovf", {31'b0, OVF}, 32'd0);
    send(15, dat(15, 1), 1'b0, 16'h0000, 1'b1);
    wait_drain("t4_drain");

    // Reset mid-frame
    OUT_READY = 1'b0;
    do_reset();
    for (int ch = 0; ch < 8; ch++) send(ch, dat(ch, 4), ch == 0, 16'h8000, 1'b1);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    exp_q.delete();
    chk("t6_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("t6_fill", {26'b0, FILL_LEVEL}, 32'd0);
    cyc();
    OUT_READY = 1'b1;
    sweep(16'h8000);
    wait_drain("t6_drain");

    sb_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
